// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the 24-bit left-justified serial transmitter
package i2s_pkg;
  localparam int DATA_W  = 24;
  localparam int BCK_DIV = 8;
  localparam int SLOTS   = 2 * DATA_W;
  localparam int FRAME   = SLOTS * BCK_DIV;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_tx_timing.sv
// i2s_tx_timing: single frame counter deriving BCK, LRCK and slot/frame strobes
//   SCK/reset_n : master clock, async active-low reset
//   running     : block is currently in RUN
//   run_next    : block will be in RUN after this edge
//   BCK/LRCK    : registered bit clock and word select (both 0 when idle)
//   slot_end    : last SCK of a BCK period (shift register advances at this edge)
//   frame_end   : last SCK of the frame (frame load or stop at this edge)
module i2s_tx_timing #(
  parameter int DATA_W  = i2s_pkg::DATA_W,
  parameter int BCK_DIV = i2s_pkg::BCK_DIV
) (
  input  logic SCK,
  input  logic reset_n,
  input  logic running,
  input  logic run_next,
  output logic BCK,
  output logic LRCK,
  output logic slot_end,
  output logic frame_end
);
  localparam int FRAME = 2 * DATA_W * BCK_DIV;
  localparam int CNT_W = $clog2(FRAME);
  localparam int DIV_W = $clog2(BCK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(FRAME / 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bck_q, bck_d, lrck_q, lrck_d;
  assign slot_end  = running && (&cnt_q[DIV_W-1:0]);
  assign frame_end = running && (cnt_q == LAST);
  // BCK and LRCK are decoded from the next count so both land registered in
  // the same cycle as the count itself; one counter means they cannot drift.
  always_comb begin
    cnt_d  = (running && run_next && !frame_end) ? cnt_q + 1'b1 : '0;
    bck_d  = run_next && cnt_d[DIV_W-1];
    lrck_d = run_next && (cnt_d < HALF);
  end
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      bck_q  <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bck_q  <= bck_d;
      lrck_q <= lrck_d;
    end
  end
  assign BCK  = bck_q;
  assign LRCK = lrck_q;
endmodule

// File: rtl/i2s_serializer.sv
// i2s_serializer: stereo left-justified serial transmitter with valid/ready sample input
//   SCK/reset_n             : master clock, async active-low reset
//   enable                  : start/stop transmission (stops only at frame end)
//   in_valid/in_ready       : handshake for the {in_left, in_right} pair
//   BCK/LRCK/SD             : serial link outputs (LRCK high = left)
//   frame_start             : one-cycle pulse at each frame load
//   underrun/clear_underrun : sticky "frame sent without a sample" flag and its clear
module i2s_serializer
  import i2s_pkg::state_t, i2s_pkg::IDLE, i2s_pkg::RUN;
#(
  parameter int DATA_W  = i2s_pkg::DATA_W,
  parameter int BCK_DIV = i2s_pkg::BCK_DIV
) (
  input  logic              SCK,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  output logic              BCK,
  output logic              LRCK,
  output logic              SD,
  output logic              frame_start,
  output logic              underrun,
  input  logic              clear_underrun
);
  localparam int SLOTS = 2 * DATA_W;
  state_t state_q, state_d;
  logic hold_full_q, hold_full_d, frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [SLOTS-1:0] hold_q, hold_d, shift_q, shift_d;
  logic running, run_next, load, accept, slot_end, frame_end;
  i2s_tx_timing #(.DATA_W(DATA_W), .BCK_DIV(BCK_DIV)) u_timing (
    .SCK      (SCK),
    .reset_n  (reset_n),
    .running  (running),
    .run_next (run_next),
    .BCK      (BCK),
    .LRCK     (LRCK),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );
  // A frame load happens on entry to RUN or at a frame wrap while enabled.
  // With enable low the current frame finishes and the block drops to IDLE.
  always_comb begin
    running       = state_q == RUN;
    run_next      = enable || (running && !frame_end);
    load          = enable && (!running || frame_end);
    accept        = in_valid && !hold_full_q;
    state_d       = run_next ? RUN : IDLE;
    hold_full_d   = (load && hold_full_q) ? 1'b0 : accept ? 1'b1 : hold_full_q;
    hold_d        = accept ? {in_left, in_right} : hold_q;
    shift_d       = load ? (hold_full_q ? hold_q : '0) :
                    !run_next ? '0 :
                    slot_end ? shift_q << 1 : shift_q;
    underrun_d    = (load && !hold_full_q) ? 1'b1 : clear_underrun ? 1'b0 : underrun_q;
    frame_start_d = load;
  end
  always_ff @(posedge SCK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hold_full_q   <= 1'b0;
      hold_q        <= '0;
      shift_q       <= '0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_full_q   <= hold_full_d;
      hold_q        <= hold_d;
      shift_q       <= shift_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign in_ready    = !hold_full_q;
  assign SD          = shift_q[SLOTS-1];
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer: directed self-checking bench for i2s_serializer
module tb_i2s_serializer;
  logic SCK = 1'b0, reset_n = 1'b0, enable = 1'b0, in_valid = 1'b0, clear_underrun = 1'b0;
  logic [23:0] in_left = '0, in_right = '0;
  logic in_ready, BCK, LRCK, SD, frame_start, underrun;
  int tests = 0, fails = 0, fs_count = 0, fs0, idle_bad;
  logic last_ur;

  i2s_serializer dut (
    .SCK(SCK), .reset_n(reset_n), .enable(enable), .in_valid(in_valid),
    .in_left(in_left), .in_right(in_right), .in_ready(in_ready), .BCK(BCK),
    .LRCK(LRCK), .SD(SD), .frame_start(frame_start), .underrun(underrun),
    .clear_underrun(clear_underrun)
  );

  always #5 SCK = ~SCK;
  always @(negedge SCK) if (frame_start === 1'b1) fs_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the sample point right after a frame load (slot 0, count 0).
  // Checks BCK/LRCK/frame_start every cycle against the frame timing and
  // captures SD at every BCK rising sample (count % 8 == 4).
  task automatic run_frame(input string tag, input logic [47:0] exp);
    logic [47:0] got = '0;
    int terr = 0;
    for (int k = 0; k < 384; k++) begin
      if (BCK !== k[2] || LRCK !== (k < 192) || frame_start !== (k == 0)) terr++;
      if (k % 8 == 4) got = {got[46:0], SD};
      if (k == 383) last_ur = underrun;
      @(negedge SCK);
    end
    check({tag, "_timing"}, terr, 0);
    check({tag, "_data"}, got, exp);
  endtask

  initial begin
    repeat (3) @(negedge SCK);
    check("rst_bck", BCK, 0);
    check("rst_lrck", LRCK, 0);
    check("rst_sd", SD, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_underrun", underrun, 0);
    check("rst_frame_start", frame_start, 0);
    reset_n = 1'b1;
    fs0 = fs_count;
    idle_bad = 0;
    repeat (1000) begin
      @(negedge SCK);
      if ({BCK, LRCK, SD, in_ready, underrun} !== 5'b00010) idle_bad++;
    end
    check("idle_outputs", idle_bad, 0);
    check("idle_no_frame_start", fs_count - fs0, 0);

    in_left = 24'h800001; in_right = 24'h7FFFFF; in_valid = 1'b1;
    @(negedge SCK);
    in_valid = 1'b0;
    check("accept_ready_low", in_ready, 0);
    enable = 1'b1;
    @(negedge SCK);
    check("t0_frame_start", frame_start, 1);
    check("t0_lrck", LRCK, 1);
    check("t0_bck", BCK, 0);
    check("t0_sd_msb", SD, 1);
    check("t0_in_ready", in_ready, 1);
    run_frame("f1", 48'h800001_7FFFFF);
    check("f1_no_underrun", last_ur, 0);
    check("f2_underrun_set", underrun, 1);
    run_frame("f2_zero", 48'h0);
    check("f3_underrun_sticky", underrun, 1);

    fork
      run_frame("f3_zero", 48'h0);
      begin
        repeat (50) @(negedge SCK);
        clear_underrun = 1'b1;
        @(negedge SCK);
        clear_underrun = 1'b0;
        check("clear_underrun", underrun, 0);
        repeat (332) @(negedge SCK);
        clear_underrun = 1'b1;
        @(negedge SCK);
        clear_underrun = 1'b0;
        check("set_beats_clear", underrun, 1);
      end
    join

    fork
      run_frame("f4_zero", 48'h0);
      begin
        repeat (10) @(negedge SCK);
        in_left = 24'h123456; in_right = 24'hABCDEF; in_valid = 1'b1;
        @(negedge SCK);
        check("a_accepted", in_ready, 0);
        in_left = 24'hF0F0F0; in_right = 24'h0F1E2D;
        repeat (372) @(negedge SCK);
        check("b_stalled", in_ready, 0);
        @(negedge SCK);
        check("ready_with_frame_start", in_ready, 1);
      end
    join
    fork
      run_frame("f5_a", 48'h123456_ABCDEF);
      begin
        @(negedge SCK);
        check("b_accepted", in_ready, 0);
        in_valid = 1'b0;
      end
    join
    fork
      run_frame("f6_b", 48'hF0F0F0_0F1E2D);
      begin
        repeat (100) @(negedge SCK);
        enable = 1'b0;
      end
    join
    check("stop_frame_start", frame_start, 0);
    check("stop_lrck", LRCK, 0);
    check("stop_bck", BCK, 0);
    check("stop_sd", SD, 0);
    fs0 = fs_count;
    repeat (500) @(negedge SCK);
    check("stop_no_extra_frame", fs_count - fs0, 0);
    check("stop_idle_lrck", LRCK, 0);

    in_left = 24'h555555; in_right = 24'hAAAAAA; in_valid = 1'b1;
    @(negedge SCK);
    in_valid = 1'b0;
    enable = 1'b1;
    @(negedge SCK);
    check("c_frame_start", frame_start, 1);
    repeat (20) @(negedge SCK);
    in_left = 24'h111111; in_right = 24'h222222; in_valid = 1'b1;
    @(negedge SCK);
    in_valid = 1'b0;
    check("d_held", in_ready, 0);
    repeat (229) @(negedge SCK);
    check("pre_reset_in_ready", in_ready, 0);
    check("pre_reset_underrun", underrun, 1);
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_lrck", LRCK, 0);
    check("async_rst_bck", BCK, 0);
    check("async_rst_sd", SD, 0);
    check("async_rst_frame_start", frame_start, 0);
    repeat (3) @(negedge SCK);
    reset_n = 1'b1;
    fs0 = fs_count;
    repeat (10) @(negedge SCK);
    check("post_rst_idle_lrck", LRCK, 0);
    check("post_rst_no_frame", fs_count - fs0, 0);
    check("post_rst_in_ready", in_ready, 1);
    enable = 1'b1;
    @(negedge SCK);
    check("post_rst_frame_start", frame_start, 1);
    check("post_rst_underrun", underrun, 1);
    fork
      run_frame("post_rst_zero", 48'h0);
      begin
        repeat (10) @(negedge SCK);
        enable = 1'b0;
      end
    join
    check("final_idle_lrck", LRCK, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
